// File: rtl/lau_pkg.sv
// Shared types for the arithmetic/LAU library: speed selector and the dec_b_counter FSM states.
package lau_pkg;

   typedef enum logic {SLOW, FAST} speed_e;

   typedef enum logic {DEC_IDLE, DEC_RUN} dec_state_e;

   // Number of doubling stages a log-depth prefix network needs for n inputs.
   function automatic int unsigned prefix_levels(input int unsigned n);
      int unsigned lv;
      lv = 0;
      while ((1 << lv) < n) lv++;
      return lv;
   endfunction

endpackage

// File: rtl/behavioural_dec_b.sv
// Reference decrementer used only as the golden side of equivalence checks against dec_b.
module behavioural_dec_b #(
   parameter int width = 8
) (
   input  logic [width-1:0] a,
   input  logic             bi,
   output logic [width-1:0] z,
   output logic             bo
);

   assign {bo, z} = {1'b0, a} - (width + 1)'(bi);

endmodule

// File: rtl/dec_b.sv
// Combinational decrementer {bo,z} = a - bi built on prefix_and: the borrow reaches bit i
// only when bi is set and every lower bit of a is zero.
module dec_b
   import lau_pkg::*;
#(
   parameter int     width = 8,
   parameter speed_e speed = FAST
) (
   input  logic [width-1:0] a,
   input  logic             bi,
   output logic [width-1:0] z,
   output logic             bo
);

   logic [width:0] po;

   prefix_and #(
      .n     (width + 1),
      .speed (speed)
   ) u_prefix (
      .x  ({~a, bi}),
      .po (po)
   );

   assign z  = a ^ po[width-1:0];
   assign bo = po[width];

endmodule

// File: rtl/prefix_and.sv
// Parallel-prefix AND: po[i] = &x[i:0]. FAST builds a log-depth Kogge-Stone tree, SLOW a ripple chain.
module prefix_and
   import lau_pkg::*;
#(
   parameter int     n     = 9,
   parameter speed_e speed = FAST
) (
   input  logic [n-1:0] x,
   output logic [n-1:0] po
);

   localparam int unsigned levels = prefix_levels(n);

   if (speed == FAST && levels > 0) begin : g_tree
      for (genvar k = 0; k < levels; k++) begin : g_lvl
         logic [n-1:0] prev;
         logic [n-1:0] v;
         if (k == 0) begin : g_first
            assign prev = x;
         end else begin : g_next
            assign prev = g_lvl[k-1].v;
         end
         // Each stage doubles the span already covered by every bit.
         for (genvar i = 0; i < n; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_and
               assign v[i] = prev[i] & prev[i-(1<<k)];
            end else begin : g_pass
               assign v[i] = prev[i];
            end
         end
      end
      assign po = g_lvl[levels-1].v;
   end else begin : g_ripple
      logic acc;
      always_comb begin
         acc = 1'b1;
         po  = '0;
         for (int i = 0; i < n; i++) begin
            acc   = acc & x[i];
            po[i] = acc;
         end
      end
   end

endmodule

// File: rtl/dec_b_counter.sv
// Loadable down-counter with registered borrow-out pulse, one-shot / auto-reload modes.
// Build option: define LAU_DEC_SAT_EN to hold q at zero after a one-shot underflow instead of wrapping.
module dec_b_counter
   import lau_pkg::*;
#(
   parameter int     width = 8,
   parameter speed_e speed = FAST
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             ld,
   input  logic [width-1:0] d,
   input  logic             en,
   input  logic             rld,
   output logic [width-1:0] q,
   output logic             bo,
   output logic             tc,
   output logic             busy
);

   dec_state_e       state, state_nxt;
   logic [width-1:0] r, r_nxt, q_nxt;
   logic             bo_nxt;
   logic [width-1:0] dec_z;
   logic             dec_bo;

   // en doubles as the borrow-in, so dec_bo flags the underflow cycle directly.
   dec_b #(
      .width (width),
      .speed (speed)
   ) u_dec (
      .a  (q),
      .bi (en),
      .z  (dec_z),
      .bo (dec_bo)
   );

   always_comb begin
      // NOTE: every output gets a default before any branch so no latch is inferred.
      state_nxt = state;
      q_nxt     = q;
      r_nxt     = r;
      bo_nxt    = 1'b0;
      if (ld) begin
         q_nxt     = d;
         r_nxt     = d;
         state_nxt = DEC_RUN;
      end else if (state == DEC_RUN && en) begin
         q_nxt = dec_z;
         if (dec_bo) begin
            bo_nxt = 1'b1;
            if (rld) begin
               q_nxt = r;
            end else begin
               state_nxt = DEC_IDLE;
`ifdef LAU_DEC_SAT_EN
               q_nxt = '0;
`else
               q_nxt = dec_z;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!rstn) begin
         state <= DEC_IDLE;
         q     <= '0;
         r     <= '0;
         bo    <= 1'b0;
      end else begin
         state <= state_nxt;
         q     <= q_nxt;
         r     <= r_nxt;
         bo    <= bo_nxt;
      end
   end

   assign tc   = (q == '0);
   assign busy = (state == DEC_RUN);

endmodule
